ir_acondicionador_pulso: RTL and testbench
==========================================

Name: ir_acondicionador_pulso

Overview:
- Front end of the infrared people/object counter.
- Takes the raw, asynchronous IR receiver output.
- Synchronises it and debounces it in both directions with a 4-state FSM.
- Emits exactly one glitch-free, single-cycle pulse per confirmed beam interruption on `cuenta`, which drives the downstream 10-bit counter's count input directly.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable samples needed to confirm a level change (1 ms at 50 MHz); legal range >= 1.
- CNT_W, 16, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
- SENSOR_ACTIVE_LOW, 1, 1 = `ir_in` low means beam blocked; 0 = high means blocked.
- STUCK_CYCLES, 50000000, blocked duration that raises the fault (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ir_in  input  1  raw IR receiver level; asynchronous to clk.
- cuenta  output  1  one-cycle count pulse, driven directly from a flop.
- objeto  output  1  debounced level; 1 = beam currently blocked.
- falla  output  1  stuck-beam fault flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset: asynchronous, active-low. State = LIBRE; debounce counter = 0; sync flops = not-blocked value; cuenta = 0; objeto = 0; falla = 0.
- Synchroniser: 2-flop chain on ir_in. Polarity-correct after the second flop to give `s` (1 = blocked).
- FSM states: LIBRE, CONFIRMA_BLOQ, BLOQUEADO, CONFIRMA_LIBRE.
- LIBRE:
  - s=1 -> CONFIRMA_BLOQ, cnt <= 0.
- CONFIRMA_BLOQ:
  - s=0 -> LIBRE (glitch rejected, no pulse).
  - s=1 and cnt == DEBOUNCE_CYCLES-1 -> BLOQUEADO, cuenta <= 1.
  - otherwise cnt <= cnt+1.
- BLOQUEADO:
  - s=0 -> CONFIRMA_LIBRE, cnt <= 0.
- CONFIRMA_LIBRE:
  - s=1 -> BLOQUEADO (no new pulse).
  - s=0 and cnt == DEBOUNCE_CYCLES-1 -> LIBRE.
  - otherwise cnt <= cnt+1.
- cuenta:
  - High for exactly one cycle after entering BLOQUEADO from CONFIRMA_BLOQ; 0 in every other cycle.
  - Never asserted on the CONFIRMA_LIBRE -> BLOQUEADO path.
- objeto: registered; 1 in BLOQUEADO and CONFIRMA_LIBRE, 0 otherwise.
- Latency: cuenta rises DEBOUNCE_CYCLES+2 clock edges after the edge that first captures the blocked level into the first sync flop.
- Counter arithmetic: cnt is unsigned CNT_W bits and is never allowed to wrap; the compare-to-limit transition always fires first.
- Minimum spacing between pulses: 2*DEBOUNCE_CYCLES+2 cycles. A faster toggle than that produces no extra pulses.
- Reset mid-debounce: pending confirmation is discarded and no pulse is emitted. If cuenta is high when rst_n falls, it drops immediately.
- Sensor already blocked at reset release: a full debounce runs, then one pulse is emitted.

Optional Feature:
- Macro: IR_STUCK_TIMEOUT_EN.
- Defined:
  - A second counter (width clog2(STUCK_CYCLES+1)) increments while in BLOQUEADO and CONFIRMA_LIBRE; it saturates and does not wrap.
  - On reaching STUCK_CYCLES, falla <= 1.
  - falla is sticky until the FSM re-enters LIBRE; the timer clears in the same cycle.
  - Counting pulses are unaffected.
- Undefined: no timer logic is built; falla is constant 0.

Decomposition:
- Shared package ir_pkg holds:
  - state enum (LIBRE, CONFIRMA_BLOQ, BLOQUEADO, CONFIRMA_LIBRE);
  - default DEBOUNCE_CYCLES and STUCK_CYCLES constants;
  - the `s` polarity convention (blocked = 1).
- One sub-module, sincronizador_2ff (1-bit, reset value parameterised), reused by other sensor inputs.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20, SENSOR_ACTIVE_LOW=1):
- Clean interruption: ir_in low for 30 cycles, then high -> exactly one cuenta pulse, 6 edges after the capture edge; objeto high from that pulse until 6 edges after ir_in rises.
- Glitches: 3-cycle low pulses on ir_in, repeated 10 times with 10-cycle gaps -> cuenta never asserts; objeto stays 0.
- Chatter on release: while BLOQUEADO, apply 2-cycle highs every 5 cycles for 40 cycles, then steady low -> zero additional pulses; objeto stays 1 throughout.
- Reset mid-operation: assert rst_n=0 while in CONFIRMA_BLOQ at cnt=2 -> all outputs 0 at once; after release with ir_in still low, one pulse DEBOUNCE_CYCLES+2 edges later.
- Burst of 5 objects (low 10 / high 10 cycles) feeding the downstream counter -> cuenta pulses = 5; downstream count reads 5.
- With IR_STUCK_TIMEOUT_EN: hold ir_in low for 40 cycles -> falla rises 20 cycles after entering BLOQUEADO; falla clears on return to LIBRE. Without the macro -> falla stays 0.

Source files
------------

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared state encoding, default timings and blocked-level convention for IR sensor front ends
package ir_pkg;

  typedef enum logic [1:0] {
    LIBRE          = 2'd0,
    CONFIRMA_BLOQ  = 2'd1,
    BLOQUEADO      = 2'd2,
    CONFIRMA_LIBRE = 2'd3
  } estado_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;     // 1 ms at 50 MHz
  localparam int STUCK_CYCLES_DEF    = 50000000;  // 1 s at 50 MHz

  // Internal level `s`: this value always means "beam blocked", whatever the receiver polarity.
  localparam logic S_BLOQUEADO = 1'b1;

  function automatic logic a_nivel_s(input logic nivel, input bit activo_bajo);
    return ((nivel == 1'b0) == activo_bajo) ? S_BLOQUEADO : ~S_BLOQUEADO;
  endfunction

  function automatic logic nivel_libre(input bit activo_bajo);
    return activo_bajo ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - 1-bit two-flop synchroniser with parameterised reset value
module sincronizador_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ir_acondicionador_pulso.sv
// rtl/ir_acondicionador_pulso.sv - IR beam conditioner: sync, two-way debounce, one count pulse per interruption
// Optional stuck-beam fault timer is built when IR_STUCK_TIMEOUT_EN is defined.
module ir_acondicionador_pulso
  import ir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W             = 16,
  parameter bit SENSOR_ACTIVE_LOW = 1'b1,
  parameter int STUCK_CYCLES      = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_in,
  output logic cuenta,
  output logic objeto,
  output logic falla
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  estado_t          r_state;
  estado_t          w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_cuenta;
  logic             w_cuenta_next;
  logic             r_objeto;
  logic             w_objeto_next;
  logic             w_raw_sync;
  logic             w_s;

  sincronizador_2ff #(
    .RST_VAL (nivel_libre(SENSOR_ACTIVE_LOW))
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ir_in),
    .o_q   (w_raw_sync)
  );

  assign w_s = a_nivel_s(w_raw_sync, SENSOR_ACTIVE_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LIBRE;
      r_cnt    <= '0;
      r_cuenta <= 1'b0;
      r_objeto <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_cuenta <= w_cuenta_next;
      r_objeto <= w_objeto_next;
    end
  end

  // The limit compare is tested before the increment, so cnt never passes LIMITE.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_cuenta_next = 1'b0;
    unique case (r_state)
      LIBRE: begin
        if (w_s == S_BLOQUEADO) begin
          w_state_next = CONFIRMA_BLOQ;
          w_cnt_next   = '0;
        end
      end
      CONFIRMA_BLOQ: begin
        if (w_s != S_BLOQUEADO) begin
          w_state_next = LIBRE;
        end else if (r_cnt == LIMITE) begin
          w_state_next  = BLOQUEADO;
          w_cuenta_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      BLOQUEADO: begin
        if (w_s != S_BLOQUEADO) begin
          w_state_next = CONFIRMA_LIBRE;
          w_cnt_next   = '0;
        end
      end
      CONFIRMA_LIBRE: begin
        if (w_s == S_BLOQUEADO) begin
          w_state_next = BLOQUEADO;
        end else if (r_cnt == LIMITE) begin
          w_state_next = LIBRE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    endcase
    w_objeto_next = (w_state_next == BLOQUEADO) || (w_state_next == CONFIRMA_LIBRE);
  end

  assign cuenta = r_cuenta;
  assign objeto = r_objeto;

`ifdef IR_STUCK_TIMEOUT_EN
  localparam int               STK_W   = $clog2(STUCK_CYCLES + 1);
  localparam logic [STK_W-1:0] STK_LIM = STK_W'(STUCK_CYCLES);

  logic [STK_W-1:0] r_stuck;
  logic             r_falla;
  logic             w_en_bloq;

  // Timer and fault clear on the same edge the FSM returns to LIBRE.
  assign w_en_bloq = ((r_state == BLOQUEADO) || (r_state == CONFIRMA_LIBRE)) &&
                     (w_state_next != LIBRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stuck <= '0;
      r_falla <= 1'b0;
    end else if (!w_en_bloq) begin
      r_stuck <= '0;
      r_falla <= 1'b0;
    end else if (r_stuck != STK_LIM) begin
      r_stuck <= r_stuck + STK_W'(1);
      if (r_stuck == STK_LIM - STK_W'(1)) begin
        r_falla <= 1'b1;
      end
    end
  end

  assign falla = r_falla;
`else
  logic w_unused_stuck;
  assign w_unused_stuck = (STUCK_CYCLES > 0);
  assign falla          = 1'b0;
`endif

endmodule

// File: tb/tb_ir_acondicionador_pulso.sv
// tb/tb_ir_acondicionador_pulso.sv - randomized self-checking bench against a run-length debounce model
module tb_ir_acondicionador_pulso;

  localparam int D   = 4;
  localparam int STK = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ir_in = 1'b1;
  logic cuenta;
  logic objeto;
  logic falla;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a level change is confirmed after D+1 consecutive synchronised samples at the new level.
  logic [1:0] m_sync;
  logic       m_cuenta;
  logic       m_objeto;
  logic       m_falla;
  int         m_run;
  int         m_age;
  int         m_pulses = 0;

  always #5 clk = ~clk;

  ir_acondicionador_pulso #(
    .DEBOUNCE_CYCLES   (D),
    .CNT_W             (16),
    .SENSOR_ACTIVE_LOW (1'b1),
    .STUCK_CYCLES      (STK)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ir_in  (ir_in),
    .cuenta (cuenta),
    .objeto (objeto),
    .falla  (falla)
  );

  task automatic model_reset();
    m_sync   = 2'b00;
    m_cuenta = 1'b0;
    m_objeto = 1'b0;
    m_falla  = 1'b0;
    m_run    = 0;
    m_age    = 0;
  endtask

  task automatic tick();
    logic s_now;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s_now    = m_sync[1];
      m_cuenta = 1'b0;
      if (m_objeto) begin
        if (m_age < STK) m_age++;
      end else begin
        m_age = 0;
      end
      if (s_now != m_objeto) begin
        m_run++;
        if (m_run == D + 1) begin
          m_objeto = s_now;
          m_run    = 0;
          if (s_now) begin
            m_cuenta = 1'b1;
            m_pulses++;
          end else begin
            m_age = 0;
          end
        end
      end else begin
        m_run = 0;
      end
`ifdef IR_STUCK_TIMEOUT_EN
      m_falla = m_objeto && (m_age >= STK);
`else
      m_falla = 1'b0;
`endif
      m_sync[1] = m_sync[0];
      m_sync[0] = (ir_in == 1'b0);
    end
    #1;
  endtask

  task automatic settle();
    ir_in = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir_in = 1'b1;
    model_reset();
    repeat (3) tick();
    n_cmp++; if (cuenta !== 1'b0) begin n_err++; $display("FAIL reset_cuenta: got %b want 0", cuenta); end
    n_cmp++; if (objeto !== 1'b0) begin n_err++; $display("FAIL reset_objeto: got %b want 0", objeto); end
    n_cmp++; if (falla !== 1'b0) begin n_err++; $display("FAIL reset_falla: got %b want 0", falla); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_clean();
    int t_pulse = -1;
    int t_free  = -1;
    int npul    = 0;
    ir_in = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_cmp++;
      if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
        n_err++; $display("FAIL clean_low k=%0d: got %b%b%b want %b%b%b", k, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
      end
      if (cuenta === 1'b1) begin npul++; if (t_pulse < 0) t_pulse = k; end
    end
    ir_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_cmp++;
      if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
        n_err++; $display("FAIL clean_high k=%0d: got %b%b%b want %b%b%b", k, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
      end
      if (cuenta === 1'b1) npul++;
      if (objeto === 1'b0 && t_free < 0) t_free = k;
    end
    n_cmp++; if (t_pulse != D + 3) begin n_err++; $display("FAIL clean_latency: pulse at edge %0d want %0d", t_pulse, D + 3); end
    n_cmp++; if (npul != 1) begin n_err++; $display("FAIL clean_pulses: got %0d want 1", npul); end
    n_cmp++; if (t_free != D + 3) begin n_err++; $display("FAIL clean_release: objeto fell at edge %0d want %0d", t_free, D + 3); end
  endtask

  task automatic test_glitches();
    int seen_c = 0;
    int seen_o = 0;
    for (int g = 0; g < 10; g++) begin
      for (int k = 0; k < 13; k++) begin
        ir_in = (k < 3) ? 1'b0 : 1'b1;
        tick();
        n_cmp++;
        if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
          n_err++; $display("FAIL glitch g=%0d k=%0d: got %b%b%b want %b%b%b", g, k, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
        end
        if (cuenta !== 1'b0) seen_c++;
        if (objeto !== 1'b0) seen_o++;
      end
    end
    n_cmp++; if (seen_c != 0) begin n_err++; $display("FAIL glitch_cuenta: %0d cycles high want 0", seen_c); end
    n_cmp++; if (seen_o != 0) begin n_err++; $display("FAIL glitch_objeto: %0d cycles high want 0", seen_o); end
  endtask

  task automatic test_chatter();
    int extra = 0;
    int drops = 0;
    ir_in = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 50; i++) begin
      ir_in = (i < 40 && (i % 5) < 2) ? 1'b1 : 1'b0;
      tick();
      n_cmp++;
      if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
        n_err++; $display("FAIL chatter i=%0d: got %b%b%b want %b%b%b", i, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
      end
      if (cuenta !== 1'b0) extra++;
      if (objeto !== 1'b1) drops++;
    end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL chatter_pulses: got %0d want 0", extra); end
    n_cmp++; if (drops != 0) begin n_err++; $display("FAIL chatter_objeto: %0d cycles low want 0", drops); end
    settle();
  endtask

  task automatic test_reset_mid();
    int t_pulse = -1;
    int npul    = 0;
    ir_in = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if ({cuenta, objeto, falla} !== 3'b000) begin n_err++; $display("FAIL midreset_outs: got %b%b%b want 000", cuenta, objeto, falla); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++;
      if (cuenta !== m_cuenta || objeto !== m_objeto) begin
        n_err++; $display("FAIL midreset k=%0d: got %b%b want %b%b", k, cuenta, objeto, m_cuenta, m_objeto);
      end
      if (cuenta === 1'b1) begin npul++; if (t_pulse < 0) t_pulse = k; end
    end
    n_cmp++; if (t_pulse != D + 3) begin n_err++; $display("FAIL midreset_latency: pulse at edge %0d want %0d", t_pulse, D + 3); end
    n_cmp++; if (npul != 1) begin n_err++; $display("FAIL midreset_pulses: got %0d want 1", npul); end
    rst_n = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (D + 3) tick();
    n_cmp++; if (cuenta !== m_cuenta) begin n_err++; $display("FAIL pulse_before_reset: got %b want %b", cuenta, m_cuenta); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (cuenta !== 1'b0 || objeto !== 1'b0) begin n_err++; $display("FAIL reset_drops_pulse: got %b%b want 00", cuenta, objeto); end
    repeat (2) tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_burst();
    logic [9:0] contador = '0;
    int base = m_pulses;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 20; k++) begin
        ir_in = (k < 10) ? 1'b0 : 1'b1;
        tick();
        n_cmp++;
        if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
          n_err++; $display("FAIL burst b=%0d k=%0d: got %b%b%b want %b%b%b", b, k, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
        end
        if (cuenta === 1'b1) contador = contador + 10'd1;
      end
    end
    repeat (10) begin
      tick();
      if (cuenta === 1'b1) contador = contador + 10'd1;
    end
    n_cmp++; if (contador !== 10'd5) begin n_err++; $display("FAIL burst_count: got %0d want 5", contador); end
    n_cmp++; if (m_pulses - base != 5) begin n_err++; $display("FAIL burst_model: got %0d want 5", m_pulses - base); end
  endtask

  task automatic test_random();
    int dut_pul = 0;
    int base    = m_pulses;
    int left    = 0;
    for (int i = 0; i < 400; i++) begin
      if (left == 0) begin
        ir_in = ~ir_in;
        left  = $urandom_range(1, 12);
      end
      left--;
      tick();
      n_cmp++;
      if (cuenta !== m_cuenta || objeto !== m_objeto || falla !== m_falla) begin
        n_err++; $display("FAIL random i=%0d ir=%b: got %b%b%b want %b%b%b", i, ir_in, cuenta, objeto, falla, m_cuenta, m_objeto, m_falla);
      end
      if (cuenta === 1'b1) dut_pul++;
    end
    n_cmp++; if (dut_pul != m_pulses - base) begin n_err++; $display("FAIL random_pulses: got %0d want %0d", dut_pul, m_pulses - base); end
    settle();
  endtask

  task automatic test_stuck();
    int t_bloq  = -1;
    int t_falla = -1;
    ir_in = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_cmp++;
      if (falla !== m_falla || objeto !== m_objeto) begin
        n_err++; $display("FAIL stuck k=%0d: falla/objeto got %b%b want %b%b", k, falla, objeto, m_falla, m_objeto);
      end
      if (objeto === 1'b1 && t_bloq < 0) t_bloq = k;
      if (falla === 1'b1 && t_falla < 0) t_falla = k;
    end
`ifdef IR_STUCK_TIMEOUT_EN
    n_cmp++; if (t_falla - t_bloq != STK) begin n_err++; $display("FAIL stuck_delay: got %0d want %0d", t_falla - t_bloq, STK); end
`else
    n_cmp++; if (t_falla != -1) begin n_err++; $display("FAIL stuck_disabled: falla rose at edge %0d want never", t_falla); end
`endif
    settle();
    n_cmp++; if (falla !== 1'b0) begin n_err++; $display("FAIL stuck_clear: got %b want 0", falla); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_glitches();
    test_chatter();
    test_reset_mid();
    test_burst();
    test_random();
    test_stuck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
